fifo_uart_tx: RTL

- Consumer side of the team's FIFO: drains bytes from a FIFO read port and serializes them onto a UART TX line.
- Frame format: 8N1 by default, LSB first.
- Sits between the UART TX FIFO (fifo_ctrl + register file) and the pad.
- Timing comes from the shared 16x-oversampling baud tick generator.

---
 rtl/fifo_uart_tx_pkg.sv | 24 ++
 rtl/fifo_uart_tx_if.sv | 24 ++
 rtl/fifo_uart_tx.sv | 101 ++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and
// stop-bit tick counts for the 16x baud tick generator.
package fifo_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // s_tick pulses per bit period
  localparam int OVERSAMPLE = 16;

  // s_tick counts for 1, 1.5 and 2 stop bits
  localparam int SB_TICK_1   = 16;
  localparam int SB_TICK_1P5 = 24;
  localparam int SB_TICK_2   = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial line and status, bundled between the
// FIFO/pad side (master) and the transmitter (slave).
interface fifo_uart_tx_if
  import fifo_uart_tx_pkg::*;
#(
  parameter int DBIT = 8
);
  logic            fifo_empty;
  logic [DBIT-1:0] fifo_r_data;
  logic            fifo_rd;
  logic            tx;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (
    output fifo_empty, fifo_r_data,
    input  fifo_rd, tx, tx_busy, tx_done_tick
  );

  modport slave (
    input  fifo_empty, fifo_r_data,
    output fifo_rd, tx, tx_busy, tx_done_tick
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a first-word-fall-through FIFO and sends
// each word as start / DBIT data (LSB first) / stop, paced by a 16x tick.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = SB_TICK_1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_tick,
  fifo_uart_tx_if.slave bus
);

  localparam int SW = $clog2(max_int(OVERSAMPLE, SB_TICK));
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  uart_state_t     state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            tx_r;

  // Frame sequencer; tx is registered and loaded with the level of the
  // state being entered so the line never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      tx_r  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_r <= 1'b1;
          if (!bus.fifo_empty) begin
            b     <= bus.fifo_r_data;
            s     <= '0;
            tx_r  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_BIT_LAST) begin
              s     <= '0;
              n     <= '0;
              tx_r  <= b[0];
              state <= DATA;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_BIT_LAST) begin
              s <= '0;
              b <= b >> 1;
              if (n == N_LAST) begin
                tx_r  <= 1'b1;
                state <= STOP;
              end else begin
                n    <= n + 1'b1;
                tx_r <= b[1];
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == S_STOP_LAST) begin
              s     <= '0;
              state <= IDLE;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: begin
          tx_r  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Pop is gated by reset so nothing is consumed while the block is held.
  assign bus.fifo_rd      = (state == IDLE) && !bus.fifo_empty && !reset;
  assign bus.tx           = tx_r;
  assign bus.tx_busy      = (state != IDLE);
  assign bus.tx_done_tick = (state == STOP) && s_tick && (s == S_STOP_LAST);

endmodule
